// File: rtl/delta_dram_read_arbiter.sv
// delta_dram_read_arbiter: round-robin owner of the single DRAM read port shared by NUM_REQ loaders.
// Define DELTA_DRAM_ARB_BURST_LOCK_EN to let an owner keep the port for BEATS_PER_LOCK beats.
module delta_dram_read_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS_PER_LOCK = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  output logic [DATA_W-1:0]         req_read_data,
  output logic [NUM_REQ-1:0]        req_data_ready,
  output logic                      DRAM_Read,
  output logic [ADDR_W-1:0]         DRAM_Address,
  input  logic [DATA_W-1:0]         DRAM_ReadData,
  input  logic                      DRAM_DataReady,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);
`ifdef DELTA_DRAM_ARB_BURST_LOCK_EN
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  localparam int BC_W = $clog2(BEATS_PER_LOCK) + 1;
  logic [BC_W-1:0] beat_q, beat_d;
  logic hold_q, hold_d;
`else
  typedef enum logic [0:0] {IDLE, BUSY} state_t;
`endif
  if (NUM_REQ < 2 || BEATS_PER_LOCK < 1) begin : g_bad_cfg
    $error("delta_dram_read_arbiter: NUM_REQ must be >= 2 and BEATS_PER_LOCK >= 1");
  end
  state_t state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d, last_q, last_d;
  logic [ID_W-1:0] pick, pick_hi, pick_lo;
  logic hit_hi, hit_lo;
  logic read_q, read_d;
  logic [ADDR_W-1:0] addr_q, addr_d, src_addr;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0] own_oh;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_address[g*ADDR_W +: ADDR_W];
  end
  // Lowest requester above last_q wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_read[j]) begin
        pick_lo = ID_W'(j);
        hit_lo = 1'b1;
        if (ID_W'(j) > last_q) begin
          pick_hi = ID_W'(j);
          hit_hi = 1'b1;
        end
      end
    end
  end
  assign pick = hit_hi ? pick_hi : pick_lo;
  assign src_addr = addr_arr[(state_q == IDLE) ? pick : owner_q];
  assign own_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign req_data_ready = (state_q == BUSY && DRAM_DataReady) ? own_oh : '0;
  assign req_read_data = DRAM_ReadData;
  assign DRAM_Read = read_q;
  assign DRAM_Address = addr_q;
  assign grant_id = owner_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    read_d = read_q;
    addr_d = addr_q;
`ifdef DELTA_DRAM_ARB_BURST_LOCK_EN
    beat_d = beat_q;
    hold_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (hit_lo) begin
        state_d = BUSY;
        owner_d = pick;
        addr_d = src_addr;
        read_d = 1'b1;
      end
      BUSY: if (DRAM_DataReady) begin
        last_d = owner_q;
        read_d = 1'b0;
`ifdef DELTA_DRAM_ARB_BURST_LOCK_EN
        state_d = (int'(beat_q) + 1 < BEATS_PER_LOCK) ? HOLD : IDLE;
        beat_d = (int'(beat_q) + 1 < BEATS_PER_LOCK) ? beat_q : '0;
`else
        state_d = IDLE;
`endif
      end
`ifdef DELTA_DRAM_ARB_BURST_LOCK_EN
      // Two-cycle window bridges the loader's index-update gap between beats.
      HOLD: if (|(req_read & own_oh)) begin
        state_d = BUSY;
        addr_d = src_addr;
        read_d = 1'b1;
        beat_d = beat_q + BC_W'(1);
      end else if (hold_q) begin
        state_d = IDLE;
        beat_d = '0;
      end else begin
        hold_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= ID_W'(NUM_REQ - 1);
      read_q <= 1'b0;
      addr_q <= '0;
`ifdef DELTA_DRAM_ARB_BURST_LOCK_EN
      beat_q <= '0;
      hold_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      read_q <= read_d;
      addr_q <= addr_d;
`ifdef DELTA_DRAM_ARB_BURST_LOCK_EN
      beat_q <= beat_d;
      hold_q <= hold_d;
`endif
    end
  end
endmodule

// File: doc/delta_dram_read_arbiter.md
Name: delta_dram_read_arbiter

Overview:
- Shares the single DRAM read port between NUM_REQ loader controllers: input loader, weight loader and output/partial-sum reader.
- Each requester uses the existing level protocol: hold read plus address until a data-ready pulse.
- The arbiter picks one owner round-robin, drives the DRAM port and routes the ready pulse back only to the owner.
- With burst lock enabled, an owner keeps the port across the four 32-bit beats that form one 128-bit SRAM word.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = input loader).
- ADDR_W, 32, DRAM address width.
- DATA_W, 32, DRAM data width.
- BEATS_PER_LOCK, 4, beats an owner may hold under burst lock.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- req_read  in  NUM_REQ  per-requester read request (level).
- req_address  in  NUM_REQ*ADDR_W  per-requester address; slice i = bits [i*ADDR_W +: ADDR_W].
- req_read_data  out  DATA_W  DRAM_ReadData broadcast to all requesters, combinational.
- req_data_ready  out  NUM_REQ  one-hot ready pulse to the current owner.
- DRAM_Read  out  1  DRAM read strobe (registered).
- DRAM_Address  out  ADDR_W  DRAM address (registered).
- DRAM_ReadData  in  DATA_W  DRAM read data.
- DRAM_DataReady  in  1  DRAM data-valid pulse.
- grant_id  out  clog2(NUM_REQ)  current/last owner index.
- busy  out  1  high in BUSY or HOLD.

Behaviour:
- Reset values: DRAM_Read=0, DRAM_Address=0, req_data_ready=0, grant_id=0, busy=0, state=IDLE, last_owner=NUM_REQ-1 (requester 0 wins first), beat_cnt=0.
- Reset mid-transaction aborts immediately: DRAM_Read=0 from the next edge; the pending DRAM response is dropped.

State machine: IDLE, BUSY, HOLD (HOLD exists only with the optional feature).
- IDLE:
  - If any req_read is high, select the first set bit scanning last_owner+1, last_owner+2, ... (wrapping modulo NUM_REQ).
  - At that edge latch owner, grant_id=owner, DRAM_Address=req_address[owner], DRAM_Read=1, and go to BUSY.
  - Latency: request seen in cycle t gives DRAM_Read high in cycle t+1.
- BUSY:
  - DRAM_Read=1; DRAM_Address stays at the latched value.
  - req_data_ready[owner]=DRAM_DataReady (combinational); all other bits are 0.
  - On DRAM_DataReady: last_owner=owner and DRAM_Read=0 at the next edge. Next state is HOLD if the lock is active and beat_cnt+1 < BEATS_PER_LOCK; otherwise IDLE with beat_cnt=0.
  - If the owner drops req_read before ready, the transaction still completes. The pulse is still routed; the requester ignores it.
  - Changes on req_address during BUSY are ignored.
- HOLD (lock only):
  - Waits at most 2 cycles, covering the loader's one-cycle index-update gap.
  - If req_read[owner] is high, go to BUSY with the owner's new address and beat_cnt+1; no other requester is considered.
  - If the window expires, go to IDLE with beat_cnt=0.
- Minimum gap: one non-BUSY cycle between consecutive DRAM_Read assertions.
- DRAM_DataReady outside BUSY is ignored; req_data_ready stays 0.
- Simultaneous DRAM_DataReady and a new request from another requester in BUSY: completion takes effect first; arbitration happens in the following IDLE cycle.
- Round-robin guarantees any continuously asserted request is granted within NUM_REQ transactions (within NUM_REQ*BEATS_PER_LOCK beats with lock).

Optional Feature:
- Macro: DELTA_DRAM_ARB_BURST_LOCK_EN.
- Defined: HOLD state and beat_cnt are present; an owner keeps the port for up to BEATS_PER_LOCK consecutive beats, so a 128-bit word is fetched without interleaving.
- Undefined: no HOLD state and no beat_cnt; every completion returns to IDLE and re-arbitrates, so requesters may interleave at 32-bit beat granularity.

Test Plan:
- Single request: after reset, req_read=3'b001 with address 0x100 in cycle 1, then DRAM_DataReady in cycle 4 with data 0xDEADBEEF.
  - DRAM_Read and DRAM_Address=0x100 from cycle 2; req_data_ready=3'b001 in cycle 4; req_read_data=0xDEADBEEF.
  - DRAM_Read=0 in cycle 5.
- Round-robin: all three requesters hold req_read; DRAM answers every transaction after 2 cycles.
  - Grant order 0,1,2,0,1,2 (lock off); req_data_ready is never asserted to a non-owner.
- Burst lock (macro on): requester 0 runs the 4-beat pattern (read, ready, 1-cycle drop, reread) at 0x200, 0x204, 0x208, 0x20C while requester 1 is requesting.
  - All four beats go to requester 0; requester 1 is granted on the 5th transaction.
  - With the macro off, beats alternate 0,1,0,1.
- Hold timeout (macro on): owner 0 does not reassert within 2 cycles after ready.
  - State returns to IDLE and requester 2 is granted in the following cycle.
- Reset mid-transaction: assert reset in BUSY before DRAM_DataReady.
  - Next cycle DRAM_Read=0, busy=0, grant_id=0; a late DRAM_DataReady produces req_data_ready=0.
- Spurious ready: DRAM_DataReady pulses while in IDLE.
  - req_data_ready stays 0; state stays IDLE.
